regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-port arbiter and scoreboard for the 32×32 integer register file. It shares the register file's single write port between two sources: the in-order pipeline writeback stage and the multi-cycle mul/div unit. Mul/div results are buffered in a small FIFO. The block tracks destination registers that have a mul/div result outstanding and stalls decode on RAW/WAW hazards against them. It sits between writeback and the register file's REGWRITE/ADR_WR_REG/WR_DATA inputs.

## Interface
- WIDTH, 32, data width
- DEPTH, 32, number of architectural registers; address width AW = $clog2(DEPTH)
- MD_BUF, 2, mul/div result FIFO depth (power of two, ≥2)
- STARVE_MAX, 4, consecutive starved cycles before wb_hold asserts
- clk  in  1  single clock, rising-edge state updates
- rst  in  1  reset, asynchronous, active-high
- wb_valid  in  1  pipeline writeback valid; no backpressure
- wb_rd  in  AW  pipeline destination register
- wb_data  in  WIDTH  pipeline writeback data
- md_issue  in  1  mul/div instruction leaving decode this cycle
- md_issue_rd  in  AW  its destination register
- md_valid  in  1  mul/div result valid
- md_rd  in  AW  mul/div result destination register
- md_data  in  WIDTH  mul/div result data
- md_ready  out  1  FIFO can accept a result
- dec_rs1, dec_rs2, dec_rd  in  AW each  operands of the instruction in decode
- hazard_stall  out  1  decode must stall
- wb_hold  out  1  request that the pipeline issue no writeback next cycle
- regwrite  out  1  register file write enable
- adr_wr_reg  out  AW  register file write address
- wr_data  out  WIDTH  register file write data

## Operation
- Write-port priority, combinational each cycle:
  1. wb_valid && wb_rd≠0 → pipeline write.
  2. Otherwise, FIFO non-empty → pop the head. regwrite=1 only if head rd≠0.
  3. Otherwise regwrite=0.
- Pipeline writes to x0: regwrite=0. The port counts as free, so a pop may proceed.
- FIFO push: md_valid && md_ready at the rising edge. md_ready = !full. Push and pop in the same cycle are allowed when full: the pop frees the slot, but md_ready still reads 0 (no bypass).
- Mul/div results with md_rd=0 are accepted and popped with no write.
- Scoreboard: pending[DEPTH] bits.
  - md_issue with md_issue_rd≠0 sets the bit.
  - A pop of head rd clears that bit at the end of the pop cycle.
  - If set and clear hit the same register in one cycle, set wins.
  - pending[0] is always 0.
- hazard_stall = pending[dec_rs1] | pending[dec_rs2] | pending[dec_rd], combinational.
- The pipeline must not assert md_issue while hazard_stall=1. Because of the WAW check, a pipeline writeback never targets a pending register.
- Starvation: starve_cnt increments each cycle the FIFO is non-empty and the pipeline owns the port. It clears on any pop or when the FIFO is empty, and saturates at STARVE_MAX. wb_hold = (starve_cnt==STARVE_MAX).
- The pipeline honours wb_hold by presenting wb_valid=0 in the following cycle. If the pipeline still asserts wb_valid, it keeps priority.

## Timing
- Reset (async, immediate): FIFO empty, pending all 0, starve_cnt 0.
  - While and after reset: regwrite=0, adr_wr_reg=0, wr_data=0, hazard_stall=0, wb_hold=0.
  - md_ready=0 while rst=1 and 1 after release.
- The port outputs are combinational from wb_* and the FIFO head. They are stable before the falling edge, where the register file commits.
- Pipeline write latency: 0 cycles (same cycle).
- Mul/div write latency: accepted at edge N; written in cycle N+1 at the earliest.
- A pending bit clears at the rising edge after the commit. hazard_stall therefore releases one cycle after the data is in the register file, which is conservative.
- Reset mid-operation: buffered results are discarded and pending bits are cleared. The pipeline flushes the mul/div unit concurrently.

## Structure
- Package regfile_pkg:
  - WIDTH, DEPTH, AW constants.
  - typedef reg_addr_t (logic [AW-1:0]).
  - typedef wb_req_t struct {valid, rd, data}.
- Sub-module regfile_wb_fifo: synchronous FIFO of wb_req_t with depth MD_BUF, async active-high reset, full/empty flags, and head output visible without a pop.
- The top level holds the priority mux, the scoreboard bit vector and the starvation counter.

## Test plan
- Pipeline-only: wb_valid=1, wb_rd=5, wb_data=0xDEAD_BEEF → regwrite=1, adr_wr_reg=5, wr_data=0xDEAD_BEEF in the same cycle. wb_rd=0 → regwrite=0.
- Issue, then result: md_issue_rd=7 at cycle 0 → hazard_stall=1 for dec_rs1=7. md_valid rd=7 data=42 at cycle 3 → write x7=42 in cycle 4; hazard_stall=0 from cycle 5.
- Collision: wb_valid with rd=3 every cycle while two md results (rd 8, 9) are accepted → FIFO full and md_ready=0. After 4 starved cycles wb_hold=1. On the first wb_valid=0 cycle x8 is written; x9 is written on the next free cycle.
- x0 handling: md_issue_rd=0 → no pending bit set. md result rd=0 → accepted, popped, regwrite=0, no stall.
- Async reset with FIFO holding 2 entries and pending={4,6} → outputs reset immediately, md_ready=0. After release: md_ready=1, hazard_stall=0, and no writes occur.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_pkg: shared constants and types for the register-file write-port
// arbiter. It defines the data width, the register count and address width,
// the register address type, and the write request record held in the
// mul/div result FIFO.
package regfile_pkg;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);

    typedef logic [AW-1:0] reg_addr_t;

    typedef struct packed {
        logic             valid;
        reg_addr_t        rd;
        logic [WIDTH-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: signals between the pipeline and the write-port arbiter.
//   wb_*      pipeline writeback (no backpressure)
//   md_*      mul/div issue and result handshake
//   dec_*     operands of the instruction in decode
//   outputs   md_ready, hazard_stall, wb_hold and the register file write port
// slave  = arbiter side, master = pipeline side.
interface regfile_wb_arbiter_if;
    import regfile_pkg::*;

    logic             wb_valid;
    reg_addr_t        wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic             md_issue;
    reg_addr_t        md_issue_rd;
    logic             md_valid;
    reg_addr_t        md_rd;
    logic [WIDTH-1:0] md_data;
    logic             md_ready;
    reg_addr_t        dec_rs1;
    reg_addr_t        dec_rs2;
    reg_addr_t        dec_rd;
    logic             hazard_stall;
    logic             wb_hold;
    logic             regwrite;
    reg_addr_t        adr_wr_reg;
    logic [WIDTH-1:0] wr_data;

    modport slave (
        input  wb_valid, wb_rd, wb_data, md_issue, md_issue_rd,
               md_valid, md_rd, md_data, dec_rs1, dec_rs2, dec_rd,
        output md_ready, hazard_stall, wb_hold, regwrite, adr_wr_reg, wr_data
    );

    modport master (
        output wb_valid, wb_rd, wb_data, md_issue, md_issue_rd,
               md_valid, md_rd, md_data, dec_rs1, dec_rs2, dec_rd,
        input  md_ready, hazard_stall, wb_hold, regwrite, adr_wr_reg, wr_data
    );
endinterface

// File: rtl/regfile_wb_fifo.sv
// regfile_wb_fifo: synchronous FIFO of wb_req_t that buffers mul/div results.
//   clk, rst     clock, asynchronous active-high reset
//   push/push_data   write an entry (ignored when full)
//   pop          drop the head entry (ignored when empty)
//   head         current head entry, visible without popping
//   full, empty  occupancy flags
module regfile_wb_fifo
    import regfile_pkg::*;
#(
    parameter int N = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);
    localparam int PW = $clog2(N);

    // The extra pointer bit tells full apart from empty when the indices match.
    logic [PW:0] wr_ptr, rd_ptr;
    wb_req_t     mem [N];

    logic do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between pipeline
// writeback and buffered mul/div results. It also keeps a scoreboard of
// registers that still wait for a mul/div result, and detects when the
// FIFO is being starved by the pipeline.
//   clk, rst  clock, asynchronous active-high reset
//   bus       regfile_wb_arbiter_if.slave carrying all other signals
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int MD_BUF     = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    wb_req_t          md_req, head;
    logic             full, empty, pipe_wr, pop, push, md_ready;
    logic [DEPTH-1:0] pending, pending_nxt;
    logic [SW-1:0]    starve_cnt;
    logic             regwrite;
    reg_addr_t        adr_wr_reg;
    logic [WIDTH-1:0] wr_data;

    // A pipeline write to x0 does not occupy the port.
    assign pipe_wr  = bus.wb_valid && (bus.wb_rd != '0);
    assign pop      = !rst && !empty && !pipe_wr;
    assign md_ready = !rst && !full;
    assign push     = bus.md_valid && md_ready;
    assign md_req   = '{valid: 1'b1, rd: bus.md_rd, data: bus.md_data};

    regfile_wb_fifo #(.N(MD_BUF)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (md_req),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Priority write mux. Idle value is all-zero so the port is quiet in reset.
    always_comb begin
        regwrite   = 1'b0;
        adr_wr_reg = '0;
        wr_data    = '0;
        if (!rst) begin
            if (pipe_wr) begin
                regwrite   = 1'b1;
                adr_wr_reg = bus.wb_rd;
                wr_data    = bus.wb_data;
            end else if (pop && head.valid && (head.rd != '0)) begin
                regwrite   = 1'b1;
                adr_wr_reg = head.rd;
                wr_data    = head.data;
            end
        end
    end

    // The set is applied after the clear, so a same-cycle issue to the
    // register being retired leaves it pending.
    always_comb begin
        pending_nxt = pending;
        if (pop)
            pending_nxt[head.rd] = 1'b0;
        if (bus.md_issue && (bus.md_issue_rd != '0))
            pending_nxt[bus.md_issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= pending_nxt;
    end

    // When the FIFO is non-empty and no pop happens, the pipeline owns the port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt <= '0;
        else if (empty || pop)
            starve_cnt <= '0;
        else if (pipe_wr && (starve_cnt != STARVE_LIM))
            starve_cnt <= starve_cnt + 1'b1;
    end

    assign bus.md_ready     = md_ready;
    assign bus.hazard_stall = pending[bus.dec_rs1] | pending[bus.dec_rs2] | pending[bus.dec_rd];
    assign bus.wb_hold      = (starve_cnt == STARVE_LIM);
    assign bus.regwrite     = regwrite;
    assign bus.adr_wr_reg   = adr_wr_reg;
    assign bus.wr_data      = wr_data;
endmodule
